ps2_command_out: RTL and testbench
==================================

Name: ps2_command_out

Overview:
Host-to-device PS/2 transmitter that sends one 8-bit command byte (for example a keyboard LED or reset command) to the attached device.
- Runs the full PS/2 host-request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, device ACK check.
- Sits beside the PS/2 receiver and shares the same synchronized clock-edge detector and sampled data line.
- Drives the PS/2 lines through open-drain "drive low" controls; the top level owns the tri-state buffers.

Parameters:
CLK_HOLD_CYCLES, 5050, cycles to hold PS/2 clock low before the start bit (101 us at 50 MHz).
FIRST_CLK_TIMEOUT, 750000, max cycles waiting for the first device clock falling edge after releasing the clock (15 ms).
XFER_TIMEOUT, 100000, max cycles from the first device falling edge to ACK sampled (2 ms).

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
the_command  in  8  command byte; latched on IDLE->INHIBIT
send_command  in  1  request level; sampled only in IDLE
ps2_clk_posedge  in  1  one-cycle pulse on a synchronized PS/2 clock rising edge
ps2_clk_negedge  in  1  one-cycle pulse on a synchronized PS/2 clock falling edge
ps2_data_in  in  1  synchronized PS/2 data line level
ps2_clk_drive_low  out  1  1 = pull PS/2 clock low; 0 = release
ps2_data_drive_low  out  1  1 = pull PS/2 data low; 0 = release
command_was_sent  out  1  high while in SENT
error_communication_timed_out  out  1  high while in ERROR (timeout or missing ACK)

Behaviour:
- Reset:
  - State IDLE; both drive_low outputs 0; both status flags 0; counters and shift register cleared.
  - Reset mid-transfer aborts the transfer and releases both lines on the next clk edge.
- Registers:
  - 9-bit shift register {parity, the_command}, with parity = ~^the_command (odd parity).
  - Bit counter, 0..8.
  - Timeout counter, sized by $clog2 of the largest parameter.
- IDLE:
  - Lines released.
  - send_command=1 -> latch the byte and parity, clear counters, go to INHIBIT.
- INHIBIT:
  - ps2_clk_drive_low=1, data released.
  - Count CLK_HOLD_CYCLES cycles, then go to START.
- START:
  - ps2_clk_drive_low=0, ps2_data_drive_low=1 (start bit 0).
  - Timeout counter runs.
  - ps2_clk_negedge -> go to DATA, present bit0, bit counter=0, reset timeout counter.
  - Counter reaching FIRST_CLK_TIMEOUT -> go to ERROR.
- DATA:
  - ps2_data_drive_low = ~shift[0].
  - On each ps2_clk_negedge: shift right, bit counter +1.
  - Negedge with bit counter==8 (parity has been presented) -> go to STOP.
- STOP:
  - Data released (stop bit 1).
  - Next ps2_clk_negedge -> go to ACK.
- ACK:
  - Lines released.
  - On ps2_clk_posedge: ps2_data_in=0 -> SENT; ps2_data_in=1 -> ERROR.
- Transfer timeout: in DATA, STOP and ACK, the timeout counter reaching XFER_TIMEOUT -> go to ERROR.
- SENT / ERROR:
  - Lines released; the matching flag is high.
  - Stay until send_command=0, then go to IDLE; the flag drops in the same cycle the state changes.
  - A new request needs send_command deasserted for at least one cycle.
- Edge rules:
  - Edge pulses are ignored in IDLE and INHIBIT.
  - Simultaneous posedge and negedge pulses cannot occur; if they do, negedge wins.
- Latency: command_was_sent rises 1 cycle after the ACK-sampling posedge pulse.
- Status flags are mutually exclusive and are never high outside SENT/ERROR.
- Coordination: the receiver must be held off while this block is not in IDLE; the top level does this by gating the receiver's start_receiving_data / wait_for_incoming_data.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, START, DATA, STOP, ACK, SENT, ERROR; 3 bits);
  - default timing constants for 50 MHz;
  - parity helper function.
- No sub-module; the timeout/hold counter stays inline because it is one counter reused across states.

Test Plan:
1. Send 0xED (six ones -> parity 1). Device model clocks at 12.5 kHz, samples on rising edges, and ACKs with 0. Required: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1; command_was_sent=1 until send_command drops.
2. Send 0xF4 (parity 0). Required: ps2_clk_drive_low=1 for exactly CLK_HOLD_CYCLES cycles before START, and ps2_data_drive_low=1 (start bit) before the first negedge.
3. Send 0xFF with the device model giving no ACK (data stays 1 at the ACK posedge). Required: ERROR; error_communication_timed_out=1 and command_was_sent=0.
4. Send with no device clocks, FIRST_CLK_TIMEOUT=200. Required: ERROR exactly 200 cycles after entering START, with both lines released.
5. Assert reset mid-DATA (after 4 bits). Required: next cycle both drive_low outputs are 0 and the state is IDLE. Then send 0x00 (parity 1): completes normally.
6. Hold send_command=1 through SENT. Required: no retransmit. Drop it for 1 cycle and reassert: a new INHIBIT phase starts.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default 50 MHz timing
// constants and the odd-parity helper used when a command byte is latched.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_STOP    = 3'd4,
    ST_ACK     = 3'd5,
    ST_SENT    = 3'd6,
    ST_ERROR   = 3'd7
  } ps2_tx_state_e;

  // Default timing at 50 MHz
  localparam int unsigned DEF_CLK_HOLD_CYCLES   = 5050;    // 101 us clock inhibit
  localparam int unsigned DEF_FIRST_CLK_TIMEOUT = 750000;  // 15 ms to first device clock
  localparam int unsigned DEF_XFER_TIMEOUT      = 100000;  // 2 ms for the rest of the frame

  // Odd parity: the nine bits {parity, data} carry an odd number of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic int unsigned max_of3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_command_out_if.sv
// Signal bundle between the PS/2 host logic and the command transmitter.
// The edge pulses and data level come from the shared PS/2 synchronizer;
// the drive_low outputs go to the top-level open-drain buffers.
// Handshake: send_command is a level request sampled only while the
// transmitter is idle; it stays high until command_was_sent or
// error_communication_timed_out is seen, and must drop for at least one cycle
// before the next request is recognised.
interface ps2_command_out_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       ps2_clk_posedge;
  logic       ps2_clk_negedge;
  logic       ps2_data_in;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  // Requesting side: host controller plus synchronizer
  modport master (
    output the_command, send_command, ps2_clk_posedge, ps2_clk_negedge, ps2_data_in,
    input  ps2_clk_drive_low, ps2_data_drive_low, command_was_sent,
    input  error_communication_timed_out
  );

  // Transmitter side
  modport slave (
    input  the_command, send_command, ps2_clk_posedge, ps2_clk_negedge, ps2_data_in,
    output ps2_clk_drive_low, ps2_data_drive_low, command_was_sent,
    output error_communication_timed_out
  );
endinterface

// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 command transmitter. Inhibits the bus clock, issues the
// start bit, shifts out 8 data bits LSB-first plus odd parity on device clock
// falling edges, releases data for the stop bit and checks the device ACK on
// the following rising edge. One counter serves as inhibit timer and as both
// timeouts since only one of them is ever active at a time.
module ps2_command_out
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HOLD_CYCLES   = DEF_CLK_HOLD_CYCLES,
  parameter int unsigned FIRST_CLK_TIMEOUT = DEF_FIRST_CLK_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT      = DEF_XFER_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_command_out_if.slave      bus,
  output ps2_tx_state_e         o_dbg_state
);

  localparam int unsigned CNT_MAX = max_of3(CLK_HOLD_CYCLES, FIRST_CLK_TIMEOUT, XFER_TIMEOUT);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts: the counter starts at 0 on state entry, so a phase of
  // N cycles ends when the counter holds N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_CLK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

  ps2_tx_state_e    r_state, w_state_next;
  logic [8:0]       r_shift, w_shift_next;
  logic [3:0]       r_bit_cnt, w_bit_cnt_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_posedge_only;

  // A coincident negedge masks the posedge
  assign w_posedge_only = bus.ps2_clk_posedge & ~bus.ps2_clk_negedge;

  // State, shift register and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_cnt     <= w_cnt_next;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_cnt_next     = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.send_command) begin
          w_shift_next   = {odd_parity(bus.the_command), bus.the_command};
          w_bit_cnt_next = '0;
          w_cnt_next     = '0;
          w_state_next   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_START;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_START: begin
        if (bus.ps2_clk_negedge) begin
          // Bit 0 is already in shift[0]; the transfer timeout starts now
          w_bit_cnt_next = '0;
          w_cnt_next     = '0;
          w_state_next   = ST_DATA;
        end else if (r_cnt == FIRST_LAST) begin
          w_state_next = ST_ERROR;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == XFER_LAST) begin
          w_state_next = ST_ERROR;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (bus.ps2_clk_negedge) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_next = ST_STOP;
            end else begin
              w_shift_next   = {1'b0, r_shift[8:1]};
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        if (r_cnt == XFER_LAST) begin
          w_state_next = ST_ERROR;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (bus.ps2_clk_negedge) begin
            w_state_next = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (r_cnt == XFER_LAST) begin
          w_state_next = ST_ERROR;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_posedge_only) begin
            w_state_next = bus.ps2_data_in ? ST_ERROR : ST_SENT;
          end
        end
      end
      ST_SENT, ST_ERROR: begin
        if (!bus.send_command) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Line drives and status flags decoded from the registered state
  always_comb begin
    bus.ps2_clk_drive_low             = (r_state == ST_INHIBIT);
    bus.ps2_data_drive_low            = (r_state == ST_START) ||
                                        ((r_state == ST_DATA) && !r_shift[0]);
    bus.command_was_sent              = (r_state == ST_SENT);
    bus.error_communication_timed_out = (r_state == ST_ERROR);
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out with a small PS/2 device model that
// generates clock edge pulses, samples the data line on rising edges and
// optionally ACKs. Device clock period is scaled down to 40 system cycles.
module tb_ps2_command_out;
  import ps2_pkg::*;

  localparam int unsigned HOLD  = 60;
  localparam int unsigned FIRST = 200;
  localparam int unsigned XFER  = 2000;
  localparam int          HALF  = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_command_out_if u_if();
  ps2_tx_state_e     dbg_state;
  logic              dev_data_low;

  // Open-drain data line: low if either side pulls it down
  assign u_if.ps2_data_in = ~(u_if.ps2_data_drive_low | dev_data_low);

  ps2_command_out #(
    .CLK_HOLD_CYCLES  (HOLD),
    .FIRST_CLK_TIMEOUT(FIRST),
    .XFER_TIMEOUT     (XFER)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (u_if),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Raise the request and follow the inhibit phase until START
  task automatic request(input logic [7:0] cmd, output int hold_cnt);
    @(negedge clk);
    u_if.the_command  = cmd;
    u_if.send_command = 1'b1;
    hold_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dbg_state == ST_START) break;
      if (u_if.ps2_clk_drive_low) hold_cnt++;
    end
  endtask

  // Device clocks n bits; smp[k] is the line level at the k-th rising edge.
  // sent_next is command_was_sent one cycle after the final rising edge.
  task automatic dev_clocks(input int n, input bit do_ack,
                            output logic [10:0] smp, output logic sent_next);
    smp = '0;
    sent_next = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      u_if.ps2_clk_negedge = 1'b1;
      @(negedge clk);
      u_if.ps2_clk_negedge = 1'b0;
      if (k == 10 && do_ack) dev_data_low = 1'b1;
      repeat (HALF - 2) @(negedge clk);
      @(negedge clk);
      u_if.ps2_clk_posedge = 1'b1;
      smp[k] = u_if.ps2_data_in;
      @(negedge clk);
      u_if.ps2_clk_posedge = 1'b0;
      sent_next = u_if.command_was_sent;
      dev_data_low = 1'b0;
      repeat (HALF - 2) @(negedge clk);
    end
  endtask

  // Complete request + frame; leaves send_command high
  task automatic run_xfer(input string tag, input logic [7:0] cmd, input logic par,
                          input bit do_ack, output int hold_cnt, output logic sent_next);
    logic [10:0] smp;
    request(cmd, hold_cnt);
    check({tag, "_start_state"}, 32'(dbg_state), 32'(ST_START));
    check({tag, "_start_bit"}, 32'(u_if.ps2_data_drive_low), 32'd1);
    check({tag, "_start_clk_rel"}, 32'(u_if.ps2_clk_drive_low), 32'd0);
    repeat (5) @(negedge clk);
    dev_clocks(11, do_ack, smp, sent_next);
    check({tag, "_frame"}, 32'(smp[9:0]), 32'({1'b1, par, cmd}));
  endtask

  // Drop the request and confirm return to IDLE with flags low
  task automatic release_request(input string tag);
    @(negedge clk);
    u_if.send_command = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_flags_low"},
          32'({u_if.command_was_sent, u_if.error_communication_timed_out}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   hold_cnt;
    int   n;
    logic sent_next;
    logic [10:0] smp;

    reset = 1'b1;
    u_if.the_command = '0;
    u_if.send_command = 1'b0;
    u_if.ps2_clk_posedge = 1'b0;
    u_if.ps2_clk_negedge = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_lines", 32'({u_if.ps2_clk_drive_low, u_if.ps2_data_drive_low}), 32'd0);
    check("rst_flags",
          32'({u_if.command_was_sent, u_if.error_communication_timed_out}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 0xED, parity 1, ACKed
    run_xfer("t1", 8'hED, 1'b1, 1'b1, hold_cnt, sent_next);
    check("t1_sent_latency", 32'(sent_next), 32'd1);
    check("t1_state", 32'(dbg_state), 32'(ST_SENT));
    check("t1_err_low", 32'(u_if.error_communication_timed_out), 32'd0);
    repeat (40) @(negedge clk);
    check("t1_sent_held", 32'(u_if.command_was_sent), 32'd1);
    release_request("t1");

    // 2: 0xF4, parity 0, exact inhibit length
    run_xfer("t2", 8'hF4, 1'b0, 1'b1, hold_cnt, sent_next);
    check("t2_hold_cycles", 32'(hold_cnt), 32'(HOLD));
    check("t2_sent", 32'(u_if.command_was_sent), 32'd1);
    release_request("t2");

    // 3: 0xFF, no ACK from device
    run_xfer("t3", 8'hFF, 1'b1, 1'b0, hold_cnt, sent_next);
    check("t3_state", 32'(dbg_state), 32'(ST_ERROR));
    check("t3_err", 32'(u_if.error_communication_timed_out), 32'd1);
    check("t3_sent_low", 32'(u_if.command_was_sent), 32'd0);
    release_request("t3");

    // 4: no device clocks, first-clock timeout
    request(8'h5A, hold_cnt);
    check("t4_start_state", 32'(dbg_state), 32'(ST_START));
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (dbg_state == ST_ERROR) break;
    end
    check("t4_timeout_cycles", 32'(n), 32'(FIRST));
    check("t4_err", 32'(u_if.error_communication_timed_out), 32'd1);
    check("t4_lines_rel", 32'({u_if.ps2_clk_drive_low, u_if.ps2_data_drive_low}), 32'd0);
    release_request("t4");

    // 5: reset after 4 data bits, then 0x00 completes
    request(8'hA5, hold_cnt);
    dev_clocks(4, 1'b0, smp, sent_next);
    check("t5_bits", 32'(smp[3:0]), 32'h5);
    check("t5_mid_state", 32'(dbg_state), 32'(ST_DATA));
    @(negedge clk);
    reset = 1'b1;
    u_if.send_command = 1'b0;
    @(negedge clk);
    check("t5_rst_lines", 32'({u_if.ps2_clk_drive_low, u_if.ps2_data_drive_low}), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_xfer("t5b", 8'h00, 1'b1, 1'b1, hold_cnt, sent_next);
    check("t5b_sent", 32'(u_if.command_was_sent), 32'd1);
    release_request("t5b");

    // 6: request held through SENT, then one-cycle drop retriggers
    run_xfer("t6", 8'h3C, 1'b1, 1'b1, hold_cnt, sent_next);
    repeat (100) @(negedge clk);
    check("t6_no_retx_state", 32'(dbg_state), 32'(ST_SENT));
    check("t6_no_retx_clk", 32'(u_if.ps2_clk_drive_low), 32'd0);
    u_if.send_command = 1'b0;
    @(negedge clk);
    u_if.send_command = 1'b1;
    check("t6_drop_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("t6_reinhibit", 32'(dbg_state), 32'(ST_INHIBIT));
    check("t6_reinhibit_clk", 32'(u_if.ps2_clk_drive_low), 32'd1);
    reset = 1'b1;
    u_if.send_command = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
